// File: rtl/out_buffer_2.sv
// Router output-port link transmitter: FIFO of {aux, flit} feeding a registered link stage.
// Optional same-cycle bypass into the link register when `OUT_BUFFER_BYPASS_EN is defined.
module out_buffer_2 #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [66:0] flit_in,
  input  logic        aux_in,
  input  logic        request_in,
  output logic        busy_out,
  output logic [66:0] FLIT_out,
  output logic        VALID_out,
  output logic        FWDAUX1_out,
  input  logic        BWDAUX1_in,
  input  logic        BWDAUX2_in,
  input  logic        BWDAUX3_in
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [67:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          out_free, pop, byp, wr, load;
  logic [67:0]   load_data;
  logic          unused_aux;

  assign unused_aux = BWDAUX2_in ^ BWDAUX3_in;

  assign VALID_out = (state == SEND) || (state == STALL);
  assign busy_out  = (count == CW'(DEPTH));

  // Link register can take a new flit when idle or when its current flit transfers.
  // The unused encoding is deliberately not free so nothing is popped into a state that drops it.
  assign out_free = (state == IDLE) || (VALID_out && !BWDAUX1_in);
  assign pop      = out_free && (count != '0);

`ifdef OUT_BUFFER_BYPASS_EN
  assign byp = out_free && (count == '0) && request_in;
`else
  assign byp = 1'b0;
`endif

  assign wr        = request_in && !busy_out && !byp;
  assign load      = pop || byp;
  assign load_data = pop ? mem[rd_ptr] : {aux_in, flit_in};

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:        state_nxt = load ? SEND : IDLE;
      SEND, STALL: begin
        if (BWDAUX1_in) state_nxt = STALL;
        else            state_nxt = load ? SEND : IDLE;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  // ---- FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {aux_in, flit_in};
  end

  // ---- FIFO control ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- Link stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      FLIT_out    <= '0;
      FWDAUX1_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) {FWDAUX1_out, FLIT_out} <= load_data;
    end
  end

endmodule

// File: doc/out_buffer_2.md
# out_buffer_2

Link transmitter at a router output port; the counterpart of `in_buffer_2` at the far end of the link. It accepts 67-bit flits from the crossbar/arbiter through a request/busy handshake and queues them in a small FIFO. It drives them onto the inter-router link (`FLIT_out`/`VALID_out`/`FWDAUX1_out`) and honours the downstream receiver's stall signal `BWDAUX1_in`.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `flit_in`  in  67: flit from the crossbar.
- `aux_in`  in  1: forward sideband bit, queued with the flit.
- `request_in`  in  1: crossbar offers `flit_in` this cycle.
- `busy_out`  out  1: FIFO full; a request in this cycle is not accepted.
- `FLIT_out`  out  67: link flit, registered.
- `VALID_out`  out  1: `FLIT_out` holds a flit, registered.
- `FWDAUX1_out`  out  1: sideband bit of the current link flit, registered.
- `BWDAUX1_in`  in  1: downstream stall; the current link flit is not taken this cycle.
- `BWDAUX2_in`, `BWDAUX3_in`  in  1 each: reserved and ignored. No logic depends on them.

## Operation
- FIFO entries are 68 bits: {aux, flit}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
- Write: at an edge where `request_in`=1 and `busy_out`=0, the FIFO captures {`aux_in`, `flit_in`}.
  - A request while `busy_out`=1 is dropped. The crossbar must hold the request.
- `busy_out` = (count == DEPTH). It is decoded from registered count only and never depends on `BWDAUX1_in`.
- Link transfer: a flit is delivered at an edge where `VALID_out`=1 and `BWDAUX1_in`=0.
- Output register "free" = `VALID_out`=0, or a transfer occurs at this edge.
- When the output register is free and the FIFO is non-empty, it loads the FIFO head and pops the FIFO.
- When the output register is free and the FIFO is empty, `VALID_out` goes 0. `FLIT_out` and `FWDAUX1_out` hold their last value.
- FSM, 2-bit state:
  - IDLE: `VALID_out`=0.
    - Go to SEND when a flit is loaded.
  - SEND: flit on the link, no stall seen.
    - `BWDAUX1_in`=1 → STALL. Flit is held and `FLIT_out` is stable.
    - Otherwise the flit transfers. Go to SEND if a next flit is loaded, else IDLE.
  - STALL: flit held.
    - Stay in STALL while `BWDAUX1_in`=1.
    - On release, same exits as SEND.
  - Unused encoding 2'b11 → IDLE. `VALID_out`=0 in that state.
- Simultaneous write and pop: count is unchanged, both pointers advance.
  - Writing into an empty FIFO while the output register is free: the flit is not visible until the next cycle (unless bypass is enabled).
- Reset mid-operation: all queued flits and the link flit are discarded. No partial flit is emitted.

## Timing
- Reset values:
  - `FLIT_out`=0, `VALID_out`=0, `FWDAUX1_out`=0.
  - `busy_out`=0, count=0, both pointers=0, state=IDLE.
- Latency, empty FIFO and idle link: request accepted at edge t → `VALID_out`=1 after edge t+1 (2 cycles).
- Throughput: 1 flit/cycle sustained while `BWDAUX1_in`=0.
- Stall response is same-cycle: `BWDAUX1_in` is sampled at the edge, so a stalled flit is never lost or duplicated.
  - This matches the receiver's skid behaviour: it raises stall only after capturing the flit that filled its skid register.
- `busy_out` rises the cycle after the write that fills the FIFO. It falls the cycle after the first pop from full.

## Configuration
- `OUT_BUFFER_BYPASS_EN`, defined: when count==0 and the output register is free, an accepted request loads `flit_in`/`aux_in` straight into the output register.
  - The FIFO is not written and the pointers do not move.
  - Latency is 1 cycle.
  - Order is preserved, since bypass only fires when the FIFO is empty.
- Undefined: every flit passes through the FIFO, with 2-cycle latency.

## Test plan
- Reset, then a single request with flit 67'h1_0000_0000_0000_00AB, `aux_in`=1, `BWDAUX1_in`=0:
  - `VALID_out`=1 with that flit and `FWDAUX1_out`=1 for exactly one cycle.
  - Rises 2 cycles after the request (1 with `OUT_BUFFER_BYPASS_EN`).
  - Then IDLE.
- Back-to-back requests with flits 1..6 and `BWDAUX1_in`=0:
  - Flits 1..6 appear in order on consecutive cycles.
  - `busy_out` never asserts.
- Hold `BWDAUX1_in`=1, then issue requests with flits 1..6 continuously:
  - The link holds flit 1 stable.
  - `busy_out`=1 once 4 flits are queued (DEPTH=4). Flit 6 is held off by the crossbar.
  - On release, flits 1..6 are delivered in order with none dropped.
- Pulse `BWDAUX1_in` for 1 cycle mid-stream:
  - The current flit is repeated exactly one extra cycle.
  - The next flit follows with no gap.
- FIFO full, pop and a new request in the same cycle:
  - The request is rejected because `busy_out`=1.
  - Count goes 4→3 and `busy_out` falls next cycle.
- Assert `rst` low with 3 flits queued and the link stalled:
  - `VALID_out`, `FLIT_out`, `FWDAUX1_out` and `busy_out` go 0 immediately.
  - After release, no old flit is emitted.
